// File: rtl/reg_bank.sv
// 32-entry MIPS general-purpose register bank: two combinational read ports,
// one synchronous write port, $0 hardwired to zero, $sp reset to SP_INIT.
module reg_bank #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    SP_INDEX   = 29,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'd227,
    parameter bit                    BYPASS     = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_r [DEPTH];
    logic                  wr_en_s;

    // Writes to $0 are dropped here so the stored copy of $0 never leaves zero.
    always_comb begin
        wr_en_s = 1'b0;
        if (RegWrite && (WriteReg != {ADDR_WIDTH{1'b0}})) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Register storage: async reset to the power-on image, otherwise one write per edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= (i == SP_INDEX) ? SP_INIT : {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[WriteReg] <= WriteData;
        end
    end

    // Read port 1: $0 forced to zero, optional same-cycle forwarding of the write.
    always_comb begin
        ReadData1 = {DATA_WIDTH{1'b0}};
        if (ReadReg1 == {ADDR_WIDTH{1'b0}}) begin
            ReadData1 = {DATA_WIDTH{1'b0}};
        end else if (BYPASS && !reset && RegWrite && (WriteReg == ReadReg1)) begin
            ReadData1 = WriteData;
        end else begin
            ReadData1 = regs_r[ReadReg1];
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        ReadData2 = {DATA_WIDTH{1'b0}};
        if (ReadReg2 == {ADDR_WIDTH{1'b0}}) begin
            ReadData2 = {DATA_WIDTH{1'b0}};
        end else if (BYPASS && !reset && RegWrite && (WriteReg == ReadReg2)) begin
            ReadData2 = WriteData;
        end else begin
            ReadData2 = regs_r[ReadReg2];
        end
    end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- 32-entry general-purpose register bank for the multicycle MIPS datapath.
- Directly downstream of the write-register mux: its write address is the 5-bit destination selected by that mux (rd, rt, $ra=31 or $sp=29).
- Provides two asynchronous read ports (rs, rt) that feed the A/B latches.
- Provides one synchronous write port driven by the write-data mux under control-unit RegWrite.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register address width; the depth is 2**ADDR_WIDTH.
- SP_INDEX, 29, index of the stack-pointer register.
- SP_INIT, 227, reset value of the stack-pointer register.
- BYPASS, 0, set to 1 to enable write-to-read forwarding in the same cycle.

Ports:
- clk, input, 1, system clock; rising edge active.
- reset, input, 1, asynchronous, active-high reset.
- RegWrite, input, 1, write enable from the control unit.
- ReadReg1, input, ADDR_WIDTH, read port 1 address (instruction[25:21]).
- ReadReg2, input, ADDR_WIDTH, read port 2 address (instruction[20:16]).
- WriteReg, input, ADDR_WIDTH, write address, taken from the write-register mux output.
- WriteData, input, DATA_WIDTH, data to write.
- ReadData1, output, DATA_WIDTH, contents of ReadReg1.
- ReadData2, output, DATA_WIDTH, contents of ReadReg2.

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-high (reset); it takes effect immediately, independent of clk.
- Reset state:
  - every register = 0, except register SP_INDEX = SP_INIT (227).
  - Outputs therefore read 0 for every address except 29, which reads 227, for as long as reset is held.
- Write:
  - On a rising clk edge with reset=0 and RegWrite=1, reg[WriteReg] <= WriteData.
  - Write latency is 1 edge: new data is visible on the read ports right after that edge.
  - RegWrite=0: no register changes.
- Register 0:
  - hardwired to zero; writes to address 0 are silently discarded.
  - ReadDataN is always 0 when ReadRegN = 0, including under bypass.
- Read:
  - purely combinational; ReadDataN = reg[ReadRegN]; no clock latency.
  - Both ports may address the same register; both then return the same value.
- Read during write, same address, same cycle:
  - BYPASS=0: read returns the old value until the edge, then the new value.
  - BYPASS=1: read returns WriteData while RegWrite=1 and WriteReg = ReadRegN != 0.
- Reset vs write:
  - reset asserted at a clock edge with RegWrite=1: reset wins and the write is lost.
  - Reset asserted mid-cycle: the contents return to the reset state immediately.
  - Reset deasserted: the first write is accepted on the next rising edge.
- $sp: register 29 is an ordinary register after reset and is fully writable.
- No X propagation: an unknown address on a read port never corrupts stored state.
- Implementation: storage is a reg array indexed by address; no latches are inferred.

Test Plan:
- Reset: assert reset, sweep ReadReg1 over 0..31 -> ReadData1 = 0 for all addresses except 29, which reads 227.
- Basic write/read: RegWrite=1, WriteReg=8, WriteData=32'hDEADBEEF, one edge; then ReadReg1=8, ReadReg2=8 -> both ports read DEADBEEF. Write 5 to reg 9 -> reg 8 is unchanged.
- Register 0: RegWrite=1, WriteReg=0, WriteData=32'h12345678, one edge -> ReadData1 (ReadReg1=0) = 0.
- Write gating and $sp: RegWrite=0, WriteReg=31, WriteData=7 -> reg 31 stays 0. Then RegWrite=1, WriteReg=29, WriteData=100 -> reg 29 reads 100. Then pulse reset asynchronously between edges -> reg 29 reads 227 at once and reg 8 reads 0.
- Bypass:
  - Setup: reg 10 = 1; during a cycle drive RegWrite=1, WriteReg=10, WriteData=2, ReadReg1=10.
  - BYPASS=0 -> ReadData1 = 1 before the edge and 2 after it.
  - BYPASS=1 -> ReadData1 = 2 before the edge.
- Reset/write collision: reset rises at the same edge as a write of 55 to reg 12 -> reg 12 reads 0. After release, a write of 55 to reg 12 lands on the following edge.
